// File: rtl/mem_loader_if.sv
// ---------------------------------------------------------------------------
// mem_loader_if
//
// Purpose: bundles the byte-stream input and the memory write bus of the
// memory loader so they travel as one port.
//
// Signals:
//   in_valid    stream byte is valid this cycle            (master -> slave)
//   in_ready    loader accepts a byte this cycle           (slave  -> master)
//   in_byte     stream byte, words arrive MSB first        (master -> slave)
//   in_sel      target memory, 0 = instruction, 1 = data   (master -> slave)
//   in_last     final byte of the session                  (master -> slave)
//   mem_we_ins  instruction-memory word write strobe       (slave  -> master)
//   mem_we_data data-memory word write strobe              (slave  -> master)
//   mem_addr    byte address of the word being written     (slave  -> master)
//   mem_wdata   assembled word                             (slave  -> master)
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1. The master holds in_byte/in_sel/in_last stable while in_valid
// is 1 and in_ready is 0; in_ready does not depend on in_valid.
//
// Modports: master = stream source / memory side, slave = the loader.
// ---------------------------------------------------------------------------
interface mem_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_byte;
    logic                  in_sel;
    logic                  in_last;
    logic                  mem_we_ins;
    logic                  mem_we_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        output in_valid,
        output in_byte,
        output in_sel,
        output in_last,
        input  in_ready,
        input  mem_we_ins,
        input  mem_we_data,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        input  in_sel,
        input  in_last,
        output in_ready,
        output mem_we_ins,
        output mem_we_data,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//
// Purpose: receives a byte stream, assembles big-endian DATA_WIDTH words and
// writes them into an instruction or a data memory, each with its own byte
// address counter. The processor is held in reset while a session runs and
// is released when the session completes.
//
// Parameters:
//   DATA_WIDTH  memory word width in bits (multiple of 8, >= 8)
//   ADDR_WIDTH  byte-address width of each target memory
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse that begins (or restarts) a load session
//   bus        mem_loader_if.slave: byte stream in, memory write bus out
//   cpu_reset  1 holds the processor in reset (0 only in DONE)
//   done       session completed
//   error      sticky session error (truncated word or address overflow)
//   checksum   [7:0] modulo-256 sum of accepted bytes; present only when
//              MEM_LOADER_CHECKSUM_EN is defined
//   dbg_state  current FSM state: 0 IDLE, 1 LOAD, 2 WRITE, 3 DONE
//
// Optional feature macro: MEM_LOADER_CHECKSUM_EN
//
// Timing: a word of BYTES = DATA_WIDTH/8 bytes takes BYTES LOAD cycles plus
// one WRITE cycle. All outputs are registers.
// ---------------------------------------------------------------------------
module mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    mem_loader_if.slave bus,
    output logic       cpu_reset,
    output logic       done,
    output logic       error,
`ifdef MEM_LOADER_CHECKSUM_EN
    output logic [7:0] checksum,
`endif
    output logic [1:0] dbg_state
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int CNT_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    // Counters carry one extra bit so "one past the last word" is representable.
    localparam int CW       = ADDR_WIDTH + 1;
    localparam int MEM_SPAN = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0]    STEP      = CW'(BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] word_q;
    logic [CNT_W-1:0]      byte_cnt_q;
    logic                  sel_q;
    logic                  last_q;
    logic [CW-1:0]         ins_cnt_q;
    logic [CW-1:0]         dat_cnt_q;
    logic                  error_q;
    logic                  in_ready_q;
    logic                  mem_we_ins_q;
    logic                  mem_we_data_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  cpu_reset_q;
    logic                  done_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]            checksum_q;
`endif

    // ------------------------------------------------------------------
    // Datapath decode
    // ------------------------------------------------------------------
    logic                  accept;
    logic                  word_end;
    logic                  early_last;
    logic                  go_write;
    logic                  restart;
    logic                  begin_sess;
    logic                  sel_now;
    logic [DATA_WIDTH-1:0] word_shift;
    logic [DATA_WIDTH-1:0] word_asm;
    int                    fill_sh;
    logic [CW-1:0]         tgt_cnt;
    logic                  room;

    // in_ready_q is 1 only in LOAD, so it alone qualifies the handshake.
    assign accept     = bus.in_valid && in_ready_q;
    assign word_end   = accept && (byte_cnt_q == LAST_BYTE);
    assign early_last = accept && bus.in_last && !word_end;
    assign go_write   = accept && (bus.in_last || word_end);

    assign restart    = start && ((state_q == S_LOAD) || (state_q == S_WRITE));
    // start together with in_last while idle is treated as noise.
    assign begin_sess = start && (((state_q == S_IDLE) && !bus.in_last) ||
                                  (state_q == S_DONE));

    // The target memory is chosen by the first byte of a word only.
    assign sel_now    = (byte_cnt_q == '0) ? bus.in_sel : sel_q;

    assign word_shift = (word_q << 8) | DATA_WIDTH'(bus.in_byte);
    // A truncated word is left-aligned, which zero-fills the missing low bytes.
    assign fill_sh    = 8 * (BYTES - 1 - int'(byte_cnt_q));
    assign word_asm   = word_shift << fill_sh;

    assign tgt_cnt    = sel_now ? dat_cnt_q : ins_cnt_q;
    // A write fits only if the whole word lies inside the memory.
    assign room       = (int'(tgt_cnt) + BYTES) <= MEM_SPAN;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (begin_sess) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (restart)       state_d = S_LOAD;
                else if (go_write) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (restart)     state_d = S_LOAD;
                else if (last_q) state_d = S_DONE;
                else             state_d = S_LOAD;
            end
            S_DONE: begin
                if (begin_sess) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            word_q        <= '0;
            byte_cnt_q    <= '0;
            sel_q         <= 1'b0;
            last_q        <= 1'b0;
            ins_cnt_q     <= '0;
            dat_cnt_q     <= '0;
            error_q       <= 1'b0;
            in_ready_q    <= 1'b0;
            mem_we_ins_q  <= 1'b0;
            mem_we_data_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_reset_q   <= 1'b1;
            done_q        <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            in_ready_q    <= (state_d == S_LOAD);
            done_q        <= (state_d == S_DONE);
            cpu_reset_q   <= (state_d != S_DONE);
            // Strobes are single-cycle: only a LOAD->WRITE edge raises one.
            mem_we_ins_q  <= 1'b0;
            mem_we_data_q <= 1'b0;

            if (begin_sess || restart) begin
                word_q     <= '0;
                byte_cnt_q <= '0;
                sel_q      <= 1'b0;
                last_q     <= 1'b0;
                ins_cnt_q  <= '0;
                dat_cnt_q  <= '0;
                error_q    <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                checksum_q <= '0;
`endif
            end else if (accept) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                checksum_q <= checksum_q + bus.in_byte;
`endif
                if (byte_cnt_q == '0) sel_q <= bus.in_sel;

                if (go_write) begin
                    byte_cnt_q  <= '0;
                    word_q      <= '0;
                    last_q      <= bus.in_last;
                    mem_addr_q  <= tgt_cnt[ADDR_WIDTH-1:0];
                    mem_wdata_q <= word_asm;
                    if (room) begin
                        if (sel_now) begin
                            mem_we_data_q <= 1'b1;
                            dat_cnt_q     <= dat_cnt_q + STEP;
                        end else begin
                            mem_we_ins_q  <= 1'b1;
                            ins_cnt_q     <= ins_cnt_q + STEP;
                        end
                    end else begin
                        // Memory full: drop the word, keep the counter, go on.
                        error_q <= 1'b1;
                    end
                    if (early_last) error_q <= 1'b1;
                end else begin
                    byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                    word_q     <= word_shift;
                end
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mem_we_ins  = mem_we_ins_q;
    assign bus.mem_we_data = mem_we_data_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign cpu_reset       = cpu_reset_q;
    assign done            = done_q;
    assign error           = error_q;
    assign dbg_state       = state_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    assign checksum        = checksum_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
//
// Two loaders (ADDR_WIDTH 8 and 4) receive the same byte stream. A reference
// model turns each session's byte list into the list of memory writes and
// the final error flag for either memory size; a monitor pops those writes
// as the strobes appear.
// ---------------------------------------------------------------------------
module tb_mem_loader;

    localparam int DW    = 32;
    localparam int AW_A  = 8;
    localparam int AW_B  = 4;
    localparam int BYTES = DW / 8;
    localparam logic [1:0] ST_IDLE = 2'd0;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic [7:0] in_byte  = 8'h00;
    logic       in_sel   = 1'b0;
    logic       in_last  = 1'b0;

    mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_A)) bus_a ();
    mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_B)) bus_b ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in_byte  = in_byte;
    assign bus_a.in_sel   = in_sel;
    assign bus_a.in_last  = in_last;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_byte  = in_byte;
    assign bus_b.in_sel   = in_sel;
    assign bus_b.in_last  = in_last;

    logic       cpu_reset_a, done_a, error_a;
    logic       cpu_reset_b, done_b, error_b;
    logic [1:0] dbg_a, dbg_b;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_a, checksum_b;
`endif

    mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_A)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus_a),
        .cpu_reset (cpu_reset_a),
        .done      (done_a),
        .error     (error_a),
`ifdef MEM_LOADER_CHECKSUM_EN
        .checksum  (checksum_a),
`endif
        .dbg_state (dbg_a)
    );

    mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_B)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus_b),
        .cpu_reset (cpu_reset_b),
        .done      (done_b),
        .error     (error_b),
`ifdef MEM_LOADER_CHECKSUM_EN
        .checksum  (checksum_b),
`endif
        .dbg_state (dbg_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    // Entry: {is_data, byte address, word}
    logic [40:0] exp_qa[$];
    logic [40:0] exp_qb[$];
    logic [7:0]  bq[$];
    logic        sq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic see_write(input int d, input logic we_i, input logic we_d, input logic rdy,
                             input logic [7:0] addr, input logic [DW-1:0] data);
        logic [40:0] got;
        logic [40:0] exp;
        int pending;
        if (we_i || we_d) begin
            check($sformatf("strobe_exclusive_%0d", d), 64'(we_i && we_d), 64'd0);
            check($sformatf("ready_low_in_write_%0d", d), 64'(rdy), 64'd0);
            got = {we_d, addr, data};
            pending = (d == 0) ? exp_qa.size() : exp_qb.size();
            check($sformatf("write_expected_%0d", d), 64'(pending > 0), 64'd1);
            if (pending > 0) begin
                if (d == 0) exp = exp_qa.pop_front();
                else        exp = exp_qb.pop_front();
                check($sformatf("write_%0d", d), 64'(got), 64'(exp));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            see_write(0, bus_a.mem_we_ins, bus_a.mem_we_data, bus_a.in_ready,
                      8'(bus_a.mem_addr), bus_a.mem_wdata);
            see_write(1, bus_b.mem_we_ins, bus_b.mem_we_data, bus_b.in_ready,
                      8'(bus_b.mem_addr), bus_b.mem_wdata);
        end
    end

    // Reference: split the byte list into words, pick each word's memory by
    // its first byte, zero-fill a truncated final word, and give each memory
    // 2**aw bytes of room.
    task automatic model(input int d, input int aw, input logic [7:0] bs[$], input logic ss[$],
                         input bit has_last, output bit err, output logic [7:0] sum);
        int cap;
        int n;
        int first;
        int nb;
        int cnt[2];
        logic [DW-1:0] word;
        logic sel;
        cap = 1 << aw;
        cnt[0] = 0;
        cnt[1] = 0;
        err = 1'b0;
        sum = 8'h00;
        n = bs.size();
        foreach (bs[i]) sum += bs[i];
        for (int w = 0; w * BYTES < n; w++) begin
            first = w * BYTES;
            nb = (n - first < BYTES) ? (n - first) : BYTES;
            if (nb < BYTES && !has_last) break;
            word = '0;
            for (int k = 0; k < nb; k++) word |= DW'(bs[first + k]) << (8 * (BYTES - 1 - k));
            sel = ss[first];
            if (nb < BYTES) err = 1'b1;
            if (cnt[sel] + BYTES <= cap) begin
                if (d == 0) exp_qa.push_back({sel, 8'(cnt[sel]), word});
                else        exp_qb.push_back({sel, 8'(cnt[sel]), word});
                cnt[sel] += BYTES;
            end else begin
                err = 1'b1;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s, input logic l);
        int   waited;
        logic rdy;
        waited = 0;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        in_sel   = s;
        in_last  = l;
        forever begin
            @(negedge clk);
            rdy = bus_a.in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                check("accept_timeout", 64'(rdy), 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic add_word(input logic [31:0] w, input logic s);
        for (int k = 3; k >= 0; k--) begin
            bq.push_back(w[8*k +: 8]);
            sq.push_back(s);
        end
    endtask

    task automatic add_rand(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            bq.push_back(8'($urandom_range(0, 255)));
            sq.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic clear_stim();
        bq.delete();
        sq.delete();
    endtask

    task automatic run_session(input bit has_last);
        bit         err_a, err_b;
        logic [7:0] sum_a, sum_b;
        int         waited;
        model(0, AW_A, bq, sq, has_last, err_a, sum_a);
        model(1, AW_B, bq, sq, has_last, err_b, sum_b);
        pulse_start();
        check("load_ready", 64'(bus_a.in_ready), 64'd1);
        check("load_cpu_reset", 64'(cpu_reset_a), 64'd1);
        check("load_done", 64'(done_a), 64'd0);
        for (int i = 0; i < bq.size(); i++)
            send_byte(bq[i], sq[i], has_last && (i == bq.size() - 1));
        if (has_last) begin
            waited = 0;
            while (!(done_a && done_b) && waited < 10) begin
                @(posedge clk); #1;
                waited++;
            end
            check("done_a", 64'(done_a), 64'd1);
            check("done_b", 64'(done_b), 64'd1);
            check("error_a", 64'(error_a), 64'(err_a));
            check("error_b", 64'(error_b), 64'(err_b));
            check("cpu_release_a", 64'(cpu_reset_a), 64'd0);
            check("cpu_release_b", 64'(cpu_reset_b), 64'd0);
            check("writes_left_a", 64'(exp_qa.size()), 64'd0);
            check("writes_left_b", 64'(exp_qb.size()), 64'd0);
`ifdef MEM_LOADER_CHECKSUM_EN
            check("checksum_a", 64'(checksum_a), 64'(sum_a));
            check("checksum_b", 64'(checksum_b), 64'(sum_b));
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, 64'(dbg_a), 64'(ST_IDLE));
        check({tag, "_cpu_reset"}, 64'(cpu_reset_a), 64'd1);
        check({tag, "_ready"}, 64'(bus_a.in_ready), 64'd0);
        check({tag, "_we"}, 64'({bus_a.mem_we_ins, bus_a.mem_we_data, bus_b.mem_we_ins, bus_b.mem_we_data}), 64'd0);
        check({tag, "_addr"}, 64'(bus_a.mem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(bus_a.mem_wdata), 64'd0);
        check({tag, "_done"}, 64'(done_a), 64'd0);
        check({tag, "_error"}, 64'({error_a, error_b}), 64'd0);
`ifdef MEM_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, 64'(checksum_a), 64'd0);
`endif
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Single instruction word.
        clear_stim();
        add_word(32'h0C000005, 1'b0);
        run_session(1'b1);

        // Two data words then one instruction word: independent counters.
        clear_stim();
        add_word(32'h00000000, 1'b1);
        add_word(32'h00000028, 1'b1);
        add_word(32'h11223344, 1'b0);
        run_session(1'b1);

        // 17 instruction words: last lands at 0x40; the small memory overflows.
        clear_stim();
        for (int i = 0; i < 17; i++) add_word($urandom, 1'b0);
        run_session(1'b1);

        // Truncated word AB CD.
        clear_stim();
        bq.push_back(8'hAB); sq.push_back(1'b0);
        bq.push_back(8'hCD); sq.push_back(1'b0);
        run_session(1'b1);

        // Five instruction words: the fifth does not fit 16 bytes.
        clear_stim();
        for (int i = 0; i < 5; i++) add_word($urandom, 1'b0);
        run_session(1'b1);

        // Restart mid-word: two words written, then start again.
        clear_stim();
        add_rand(2 * BYTES + 2);
        run_session(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("restart_pending_a", 64'(exp_qa.size()), 64'd0);
        clear_stim();
        add_rand(3 * BYTES);
        run_session(1'b1);

        // Reset after two bytes of a word.
        clear_stim();
        add_rand(2);
        run_session(1'b0);
        reset = 1'b1;
        #2;
        check_reset_state("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midreset_pending_a", 64'(exp_qa.size()), 64'd0);

        // start together with in_last while idle is ignored.
        in_last = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        in_last = 1'b0;
        check("idle_start_last_state", 64'(dbg_a), 64'(ST_IDLE));
        check("idle_start_last_ready", 64'(bus_a.in_ready), 64'd0);

        // Counters restart at zero after reset.
        clear_stim();
        add_word(32'hDEADBEEF, 1'b1);
        add_word(32'h0C000005, 1'b0);
        run_session(1'b1);

        // Random sessions, per-byte random in_sel.
        for (int s = 0; s < 12; s++) begin
            clear_stim();
            add_rand($urandom_range(1, 40));
            run_session(1'b1);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width in bits; a multiple of 8 and at least 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, byte-address width per target memory.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port in_valid  input  1  in_byte is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  the loader accepts a byte this cycle.
REQ-008 SHALL have port in_byte  input  8  stream byte; words arrive big-endian, first byte is the MSB.
REQ-009 SHALL have port in_sel  input  1  target memory: 0 = instruction, 1 = data; sampled on the first byte of each word.
REQ-010 SHALL have port in_last  input  1  marks the final byte of the session.
REQ-011 SHALL have port mem_we_ins  output  1  instruction-memory word write strobe.
REQ-012 SHALL have port mem_we_data  output  1  data-memory word write strobe.
REQ-013 SHALL have port mem_addr  output  ADDR_WIDTH  byte address of the word being written.
REQ-014 SHALL have port mem_wdata  output  DATA_WIDTH  assembled word.
REQ-015 SHALL have port cpu_reset  output  1  holds the processor in reset while it is 1.
REQ-016 SHALL have port done  output  1  session completed.
REQ-017 SHALL have port error  output  1  sticky session error.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, WRITE and DONE, with these transitions: IDLE -start-> LOAD; LOAD -word complete-> WRITE; WRITE -> LOAD, or -> DONE when the word carried in_last; DONE -start-> LOAD.
REQ-019 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 only in LOAD.
REQ-020 SHALL shift accepted bytes into the word register MSB-first; after BYTES = DATA_WIDTH/8 bytes the FSM SHALL enter WRITE on the next edge.
REQ-021 SHALL, in WRITE, assert for exactly one cycle the strobe selected by the latched in_sel, present mem_addr and mem_wdata stable in that cycle, and assert no other strobe.
REQ-022 SHALL keep independent address counters for the instruction and data memories; both start at 0 and each advances by BYTES after a write to its memory, so throughput is BYTES+1 cycles per word.
REQ-023 SHALL, when in_last arrives on a byte that is not the final byte of a word, zero-fill the remaining low bytes, write the partial word, set error, and enter DONE.
REQ-024 SHALL, when a write would exceed the memory's last whole-word address (counter wrap), suppress the strobe, set error, leave the counter unchanged, and continue the session.
REQ-025 SHALL ignore in_sel changes in the middle of a word.
REQ-026 SHALL treat start in LOAD or WRITE as a restart: clear the counters, the partial word and error, then enter LOAD.
REQ-027 SHALL ignore start and in_last arriving in the same cycle in IDLE.
REQ-028 SHALL hold cpu_reset at 1 in IDLE, LOAD and WRITE, drop it to 0 on entry to DONE, and raise it again on start.
REQ-029 SHALL assert done only in DONE.

Reset
REQ-030 SHALL, while reset=1, force IDLE with cpu_reset=1 and in_ready=0, mem_we_ins=0, mem_we_data=0, mem_addr=0, mem_wdata=0, done=0, error=0, and both address counters at 0.
REQ-031 SHALL, if reset is asserted mid-word, discard the partial word with no write.

Configuration
REQ-032 SHALL, with MEM_LOADER_CHECKSUM_EN defined, add output checksum [7:0] holding the modulo-256 sum of all accepted bytes; it resets to 0, clears on start, and holds its value in DONE.
REQ-033 SHALL, without MEM_LOADER_CHECKSUM_EN defined, have no checksum port or logic and leave all other behaviour identical.

Verification
REQ-034 SHALL check: start, then bytes 0C 00 00 05 with in_sel=0 -> one-cycle mem_we_ins with mem_addr=0x00 and mem_wdata=0x0C000005; in_ready=0 during the write cycle.
REQ-035 SHALL check: data words 0x00000000 then 0x00000028 with in_sel=1 -> mem_we_data at addresses 0x00 then 0x04; the instruction counter is unaffected.
REQ-036 SHALL check: in_last on the 4th byte of instruction word 17 -> write at 0x40, then done=1, cpu_reset=0, error=0.
REQ-037 SHALL check: in_last on the 2nd byte (AB CD) -> write of 0xABCD0000, then error=1 and done=1.
REQ-038 SHALL check: ADDR_WIDTH=4, 5 instruction words -> words 1-4 at 0x0, 0x4, 0x8, 0xC; the 5th is suppressed with error=1.
REQ-039 SHALL check: reset pulse after 2 bytes -> no strobe, IDLE, cpu_reset=1; with MEM_LOADER_CHECKSUM_EN, bytes 0C 00 00 05 -> checksum=0x11.
